// File: rtl/mpmem_wr_sched.sv
// -----------------------------------------------------------------------------
// mpmem_wr_sched
//
// Write scheduler that funnels NUM_REQ write requesters onto the three write
// ports of a multi-port memory, and sequences a memory initialisation.
//
// Each cycle the requesters are scanned round-robin, starting at a rotation
// pointer. A requester is granted if fewer than three grants have been issued
// so far this cycle and its address differs from every address already granted
// this cycle. The k-th grant (k = 0..2) drives write port k one cycle later.
//
// Handshake: requester i transfers on a clk edge where req_vld[i] & req_rdy[i].
//   Requesters hold req_vld/addr/data stable until req_rdy. req_rdy is
//   combinational, never depends on itself, and is all-zero unless the block
//   is idle, the memory is not busy, no init is requested and rst is low.
//
// Init sequence: IDLE --init_req--> INIT_ISSUE (init=1 for that one cycle)
//   --> WAIT_HI --busy_w=1--> WAIT_LO --busy_w=0--> IDLE (init_done pulse).
//
// Ports
//   clk, rst              clock; synchronous active-high reset
//   req_vld/addr/data     per-requester write request (requester i at
//                         bits [i*AW +: AW] / [i*W +: W])
//   req_rdy               per-requester accept (combinational)
//   wen0..2/waddr0..2/wdata0..2
//                         registered memory write ports
//   init_req              init request level, only looked at in IDLE
//   init                  registered init strobe to the memory
//   busy_w                memory busy
//   init_done             registered one-cycle pulse at the end of init
//   dbg_state             FSM state: 0 IDLE, 1 INIT_ISSUE, 2 WAIT_HI, 3 WAIT_LO
//   dbg_ptr               round-robin rotation pointer
// -----------------------------------------------------------------------------
module mpmem_wr_sched #(
  parameter int NUM_REQ = 4,
  parameter int AW      = 12,
  parameter int W       = 32,
  localparam int PW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_vld,
  input  logic [NUM_REQ*AW-1:0] req_addr,
  input  logic [NUM_REQ*W-1:0]  req_data,
  output logic [NUM_REQ-1:0]    req_rdy,
  output logic                  wen0,
  output logic                  wen1,
  output logic                  wen2,
  output logic [AW-1:0]         waddr0,
  output logic [AW-1:0]         waddr1,
  output logic [AW-1:0]         waddr2,
  output logic [W-1:0]          wdata0,
  output logic [W-1:0]          wdata1,
  output logic [W-1:0]          wdata2,
  input  logic                  init_req,
  output logic                  init,
  input  logic                  busy_w,
  output logic                  init_done,
  output logic [1:0]            dbg_state,
  output logic [PW-1:0]         dbg_ptr
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    INIT_ISSUE = 2'd1,
    WAIT_HI    = 2'd2,
    WAIT_LO    = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_t          r_state;
  logic [PW-1:0]   r_ptr;
  logic [2:0]      r_wen;
  logic [AW-1:0]   r_waddr [3];
  logic [W-1:0]    r_wdata [3];
  logic            r_init;
  logic            r_init_done;

  // ---------------------------------------------------------------------------
  // Combinational signals
  // ---------------------------------------------------------------------------
  state_t          w_next_state;
  logic            w_eligible;
  logic [AW-1:0]   w_addr [NUM_REQ];
  logic [W-1:0]    w_data [NUM_REQ];
  logic [NUM_REQ-1:0] w_rdy;
  logic [2:0]      w_gvld;
  logic [AW-1:0]   w_gaddr [3];
  logic [W-1:0]    w_gdata [3];
  logic [PW-1:0]   w_last;
  logic [PW-1:0]   w_ptr_nxt;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign w_addr[gi] = req_addr[gi*AW +: AW];
    assign w_data[gi] = req_data[gi*W +: W];
  end

  // Grants only while idle and quiet; rst is included so nothing is accepted
  // in a cycle whose write would be discarded anyway.
  assign w_eligible = (r_state == IDLE) && !busy_w && !init_req && !rst;

  // ---------------------------------------------------------------------------
  // Round-robin scan with per-cycle address de-duplication.
  // cnt counts grants issued so far and doubles as the target port index.
  // ---------------------------------------------------------------------------
  always_comb begin
    logic [1:0]    cnt;
    logic [PW:0]   sum;
    logic [PW-1:0] idx;
    logic          clash;
    w_rdy  = '0;
    w_gvld = '0;
    w_last = '0;
    for (int j = 0; j < 3; j++) begin
      w_gaddr[j] = '0;
      w_gdata[j] = '0;
    end
    cnt   = 2'd0;
    sum   = '0;
    idx   = '0;
    clash = 1'b0;
    if (w_eligible) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        // (ptr + k) mod NUM_REQ; one extra bit holds the wrap without overflow.
        sum = {1'b0, r_ptr} + (PW+1)'(k);
        if (sum >= (PW+1)'(NUM_REQ)) begin
          sum = sum - (PW+1)'(NUM_REQ);
        end
        idx   = sum[PW-1:0];
        clash = 1'b0;
        for (int j = 0; j < 3; j++) begin
          if (w_gvld[j] && (w_gaddr[j] == w_addr[idx])) begin
            clash = 1'b1;
          end
        end
        if (req_vld[idx] && (cnt != 2'd3) && !clash) begin
          w_rdy[idx]   = 1'b1;
          w_gvld[cnt]  = 1'b1;
          w_gaddr[cnt] = w_addr[idx];
          w_gdata[cnt] = w_data[idx];
          w_last       = idx;
          cnt          = cnt + 2'd1;
        end
      end
    end
  end

  // Pointer moves to just past the last requester granted this cycle.
  always_comb begin
    logic [PW:0] nxt;
    nxt = {1'b0, w_last} + (PW+1)'(1);
    if (nxt >= (PW+1)'(NUM_REQ)) begin
      nxt = '0;
    end
    w_ptr_nxt = nxt[PW-1:0];
  end

  // ---------------------------------------------------------------------------
  // FSM next state
  // ---------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:       if (init_req) w_next_state = INIT_ISSUE;
      INIT_ISSUE: w_next_state = WAIT_HI;
      WAIT_HI:    if (busy_w)   w_next_state = WAIT_LO;
      WAIT_LO:    if (!busy_w)  w_next_state = IDLE;
      default:    w_next_state = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_wen       <= '0;
      r_init      <= 1'b0;
      r_init_done <= 1'b0;
      for (int j = 0; j < 3; j++) begin
        r_waddr[j] <= '0;
        r_wdata[j] <= '0;
      end
    end else begin
      r_state     <= w_next_state;
      // init is high exactly while the FSM sits in INIT_ISSUE.
      r_init      <= (w_next_state == INIT_ISSUE);
      r_init_done <= (r_state == WAIT_LO) && !busy_w;
      r_wen       <= w_gvld;
      // Ungranted ports keep their last address/data.
      for (int j = 0; j < 3; j++) begin
        if (w_gvld[j]) begin
          r_waddr[j] <= w_gaddr[j];
          r_wdata[j] <= w_gdata[j];
        end
      end
      if (|w_gvld) begin
        r_ptr <= w_ptr_nxt;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign req_rdy   = w_rdy;
  assign wen0      = r_wen[0];
  assign wen1      = r_wen[1];
  assign wen2      = r_wen[2];
  assign waddr0    = r_waddr[0];
  assign waddr1    = r_waddr[1];
  assign waddr2    = r_waddr[2];
  assign wdata0    = r_wdata[0];
  assign wdata1    = r_wdata[1];
  assign wdata2    = r_wdata[2];
  assign init      = r_init;
  assign init_done = r_init_done;
  assign dbg_state = r_state;
  assign dbg_ptr   = r_ptr;

endmodule

// File: tb/tb_mpmem_wr_sched.sv
// -----------------------------------------------------------------------------
// tb_mpmem_wr_sched
//
// Directed scenarios for grant ordering, address collisions, the init
// sequence, busy stalls and reset, followed by a randomized phase compared
// against a queue-based reference model of the scheduling rules.
// Inputs change just after the falling edge; req_rdy is sampled 1 time unit
// later, registered outputs 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_mpmem_wr_sched;

  localparam int NUM_REQ = 4;
  localparam int AW      = 12;
  localparam int W       = 32;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_INIT = 2'd1;
  localparam logic [1:0] ST_WHI  = 2'd2;
  localparam logic [1:0] ST_WLO  = 2'd3;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic                  clk = 1'b0;
  logic                  rst;
  logic [NUM_REQ-1:0]    req_vld;
  logic [NUM_REQ*AW-1:0] req_addr;
  logic [NUM_REQ*W-1:0]  req_data;
  logic [NUM_REQ-1:0]    req_rdy;
  logic                  wen0, wen1, wen2;
  logic [AW-1:0]         waddr0, waddr1, waddr2;
  logic [W-1:0]          wdata0, wdata1, wdata2;
  logic                  init_req, init, busy_w, init_done;
  logic [1:0]            dbg_state;
  logic [1:0]            dbg_ptr;

  logic [AW-1:0]         a_q [NUM_REQ];
  logic [W-1:0]          d_q [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_pack
    assign req_addr[g*AW +: AW] = a_q[g];
    assign req_data[g*W +: W]   = d_q[g];
  end

  always #5 clk = ~clk;

  mpmem_wr_sched #(.NUM_REQ(NUM_REQ), .AW(AW), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_vld   (req_vld),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_rdy   (req_rdy),
    .wen0      (wen0),
    .wen1      (wen1),
    .wen2      (wen2),
    .waddr0    (waddr0),
    .waddr1    (waddr1),
    .waddr2    (waddr2),
    .wdata0    (wdata0),
    .wdata1    (wdata1),
    .wdata2    (wdata2),
    .init_req  (init_req),
    .init      (init),
    .busy_w    (busy_w),
    .init_done (init_done),
    .dbg_state (dbg_state),
    .dbg_ptr   (dbg_ptr)
  );

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: grants are a queue of requester indices in scan order.
  // ---------------------------------------------------------------------------
  int                 m_ptr = 0;
  logic               m_wen   [3];
  logic [AW-1:0]      m_waddr [3];
  logic [W-1:0]       m_wdata [3];
  logic [NUM_REQ-1:0] m_rdy;
  int                 m_gq[$];
  bit                 pend [NUM_REQ];

  function automatic void model_arb(input bit elig);
    m_rdy = '0;
    m_gq.delete();
    if (!elig) return;
    for (int k = 0; k < NUM_REQ; k++) begin
      int i;
      bit dup;
      i   = (m_ptr + k) % NUM_REQ;
      dup = 1'b0;
      foreach (m_gq[g]) if (a_q[m_gq[g]] == a_q[i]) dup = 1'b1;
      if (req_vld[i] && m_gq.size() < 3 && !dup) begin
        m_gq.push_back(i);
        m_rdy[i] = 1'b1;
      end
    end
  endfunction

  function automatic void model_clk(input bit r);
    if (r) begin
      m_ptr = 0;
      for (int j = 0; j < 3; j++) begin
        m_wen[j] = 1'b0; m_waddr[j] = '0; m_wdata[j] = '0;
      end
      return;
    end
    for (int j = 0; j < 3; j++) m_wen[j] = 1'b0;
    foreach (m_gq[g]) begin
      m_wen[g]   = 1'b1;
      m_waddr[g] = a_q[m_gq[g]];
      m_wdata[g] = d_q[m_gq[g]];
    end
    if (m_gq.size() > 0) m_ptr = (m_gq[m_gq.size()-1] + 1) % NUM_REQ;
  endfunction

  task automatic chk_ports(input string tag);
    chk({tag, ".wen0"},   wen0,   m_wen[0]);
    chk({tag, ".wen1"},   wen1,   m_wen[1]);
    chk({tag, ".wen2"},   wen2,   m_wen[2]);
    chk({tag, ".waddr0"}, waddr0, m_waddr[0]);
    chk({tag, ".waddr1"}, waddr1, m_waddr[1]);
    chk({tag, ".waddr2"}, waddr2, m_waddr[2]);
    chk({tag, ".wdata0"}, wdata0, m_wdata[0]);
    chk({tag, ".wdata1"}, wdata1, m_wdata[1]);
    chk({tag, ".wdata2"}, wdata2, m_wdata[2]);
  endtask

  // Safety net against a stuck simulation.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    rst = 1'b1; req_vld = '0; init_req = 1'b0; busy_w = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin a_q[i] = '0; d_q[i] = '0; end

    // Reset with requests pending: nothing accepted, outputs cleared.
    @(negedge clk);
    req_vld = 4'b1111;
    for (int i = 0; i < NUM_REQ; i++) begin a_q[i] = AW'(i + 1); d_q[i] = 32'h5000 + i; end
    #1 chk("rst.rdy", req_rdy, 4'b0000);
    @(posedge clk); #1;
    chk("rst.wen", {wen2, wen1, wen0}, 3'b000);
    chk("rst.waddr0", waddr0, 0);
    chk("rst.wdata0", wdata0, 0);
    chk("rst.init", init, 0);
    chk("rst.init_done", init_done, 0);
    chk("rst.state", dbg_state, ST_IDLE);
    chk("rst.ptr", dbg_ptr, 0);

    // Four distinct addresses: first three in one cycle, the fourth next.
    @(negedge clk);
    rst = 1'b0;
    a_q[0] = 12'h010; a_q[1] = 12'h020; a_q[2] = 12'h030; a_q[3] = 12'h040;
    for (int i = 0; i < NUM_REQ; i++) d_q[i] = 32'hA000_0000 + i;
    #1 chk("s1.rdy0", req_rdy, 4'b0111);
    @(posedge clk); #1;
    chk("s1.wen", {wen2, wen1, wen0}, 3'b111);
    chk("s1.waddr0", waddr0, 12'h010);
    chk("s1.waddr1", waddr1, 12'h020);
    chk("s1.waddr2", waddr2, 12'h030);
    chk("s1.wdata2", wdata2, 32'hA000_0002);
    chk("s1.ptr", dbg_ptr, 3);
    @(negedge clk);
    req_vld = 4'b1000;
    #1 chk("s1.rdy1", req_rdy, 4'b1000);
    @(posedge clk); #1;
    chk("s1.wen_b", {wen2, wen1, wen0}, 3'b001);
    chk("s1.waddr0_b", waddr0, 12'h040);
    chk("s1.wdata0_b", wdata0, 32'hA000_0003);
    chk("s1.waddr1_hold", waddr1, 12'h020);
    chk("s1.ptr_b", dbg_ptr, 0);

    // Same-address collision: req2 stalls behind req0.
    @(negedge clk);
    req_vld = 4'b0111;
    a_q[0] = 12'h123; a_q[1] = 12'h200; a_q[2] = 12'h123;
    d_q[0] = 32'hB0; d_q[1] = 32'hB1; d_q[2] = 32'hB2;
    #1 chk("s2.rdy0", req_rdy, 4'b0011);
    @(posedge clk); #1;
    chk("s2.wen", {wen2, wen1, wen0}, 3'b011);
    chk("s2.waddr0", waddr0, 12'h123);
    chk("s2.wdata0", wdata0, 32'hB0);
    chk("s2.waddr1", waddr1, 12'h200);
    chk("s2.ptr", dbg_ptr, 2);
    @(negedge clk);
    req_vld = 4'b0100;
    #1 chk("s2.rdy1", req_rdy, 4'b0100);
    @(posedge clk); #1;
    chk("s2.wen_b", {wen2, wen1, wen0}, 3'b001);
    chk("s2.waddr0_b", waddr0, 12'h123);
    chk("s2.wdata0_b", wdata0, 32'hB2);

    // Memory busy in IDLE stalls grants without leaving IDLE.
    @(negedge clk);
    req_vld = 4'b0001; a_q[0] = 12'h055; d_q[0] = 32'hD055; busy_w = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1 chk("s6.rdy_busy", req_rdy, 4'b0000);
      @(posedge clk); #1;
      chk("s6.wen_busy", {wen2, wen1, wen0}, 3'b000);
      chk("s6.state_busy", dbg_state, ST_IDLE);
      @(negedge clk);
    end
    busy_w = 1'b0;
    #1 chk("s6.rdy_free", req_rdy, 4'b0001);
    @(posedge clk); #1;
    chk("s6.wen0", wen0, 1);
    chk("s6.waddr0", waddr0, 12'h055);

    // Reset while requests are valid: grants discarded, ptr back to 0.
    @(negedge clk);
    rst = 1'b1; req_vld = 4'b1111;
    for (int i = 0; i < NUM_REQ; i++) a_q[i] = AW'(12'h300 + i);
    #1 chk("r2.rdy", req_rdy, 4'b0000);
    @(posedge clk); #1;
    chk("r2.wen", {wen2, wen1, wen0}, 3'b000);
    chk("r2.ptr", dbg_ptr, 0);

    // Identical addresses: one grant per cycle, rotating, port 0 only.
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin a_q[i] = '0; d_q[i] = 32'hC0 + i; end
    for (int c = 0; c < 8; c++) begin
      logic [3:0] er;
      er = 4'b0001 << (c % 4);
      #1 chk("s3.rdy", req_rdy, er);
      @(posedge clk); #1;
      chk("s3.wen", {wen2, wen1, wen0}, 3'b001);
      chk("s3.wdata0", wdata0, 32'hC0 + (c % 4));
      @(negedge clk);
    end

    // Init sequence with requests waiting.
    req_vld = 4'b1111; init_req = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) begin a_q[i] = AW'(12'h100 + i); d_q[i] = 32'hE0 + i; end
    #1 chk("s4.rdy_req", req_rdy, 4'b0000);
    @(posedge clk); #1;
    chk("s4.init_hi", init, 1);
    chk("s4.state_issue", dbg_state, ST_INIT);
    @(negedge clk);
    init_req = 1'b0;
    #1 chk("s4.rdy_issue", req_rdy, 4'b0000);
    @(posedge clk); #1;
    chk("s4.init_lo", init, 0);
    chk("s4.state_whi", dbg_state, ST_WHI);
    @(negedge clk);
    busy_w = 1'b1; init_req = 1'b1;  // init_req outside IDLE is ignored
    #1 chk("s4.rdy_whi", req_rdy, 4'b0000);
    @(posedge clk); #1;
    chk("s4.state_wlo", dbg_state, ST_WLO);
    chk("s4.init_ign", init, 0);
    chk("s4.done_early", init_done, 0);
    @(negedge clk);
    init_req = 1'b0;
    @(posedge clk); #1;
    chk("s4.state_wlo2", dbg_state, ST_WLO);
    @(negedge clk);
    @(posedge clk); #1;
    chk("s4.done_busy", init_done, 0);
    @(negedge clk);
    busy_w = 1'b0;
    #1 chk("s4.rdy_wlo", req_rdy, 4'b0000);
    @(posedge clk); #1;
    chk("s4.done_pulse", init_done, 1);
    chk("s4.state_idle", dbg_state, ST_IDLE);
    chk("s4.rdy_resume", req_rdy, 4'b0111);
    @(negedge clk);
    @(posedge clk); #1;
    chk("s4.done_once", init_done, 0);
    chk("s4.wen_resume", {wen2, wen1, wen0}, 3'b111);
    chk("s4.waddr0", waddr0, 12'h100);

    // Reset in WAIT_LO aborts init with no done pulse.
    @(negedge clk);
    req_vld = 4'b0000; init_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    init_req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    busy_w = 1'b1;
    @(posedge clk); #1;
    chk("s5.state_wlo", dbg_state, ST_WLO);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("s5.state", dbg_state, ST_IDLE);
    chk("s5.init", init, 0);
    chk("s5.init_done", init_done, 0);
    chk("s5.wen", {wen2, wen1, wen0}, 3'b000);
    @(negedge clk);
    rst = 1'b0; busy_w = 1'b0;
    @(posedge clk); #1;
    chk("s5.no_done", init_done, 0);
    chk("s5.state_after", dbg_state, ST_IDLE);

    // Randomized phase against the reference model; first cycle resets.
    for (int i = 0; i < NUM_REQ; i++) pend[i] = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      rst    = (c == 0) || ($urandom_range(0, 59) == 0);
      busy_w = ($urandom_range(0, 5) == 0);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!pend[i] && $urandom_range(0, 2) != 0) begin
          pend[i] = 1'b1;
          a_q[i]  = AW'($urandom_range(0, 5));
          d_q[i]  = $urandom;
        end
        req_vld[i] = pend[i];
      end
      #1;
      model_arb(!rst && !busy_w);
      chk("rnd.rdy", req_rdy, m_rdy);
      model_clk(rst);
      for (int i = 0; i < NUM_REQ; i++) if (m_rdy[i]) pend[i] = 1'b0;
      @(posedge clk); #1;
      chk_ports("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
